cs_y_collector: RTL and testbench

Downstream capture stage for the CS computational system. Samples the 10-bit CS result `Y` once per clock and discards a configurable warm-up count after reset. Tags each kept sample with a sequence number and buffers it in a show-ahead FIFO drained over a valid/ready handshake. Overflow is reported as a sticky flag, so the non-stallable CS pipeline never needs backpressure.

---
 rtl/cs_y_collector.sv | 105 ++++++++++
 tb/tb_cs_y_collector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cs_y_collector.sv
// cs_y_collector: captures the CS result Y once per enabled clock, drops a
// warm-up count after reset, tags kept samples with a sequence number and
// buffers them in a show-ahead FIFO drained over valid/ready. Overflow is a
// sticky flag; the producer is never stalled.
module cs_y_collector #(
    parameter int DEPTH = 16,
    parameter int SKIP  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 y_in,
    input  logic                       en,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [9:0]                 out_data,
    output logic [7:0]                 out_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [9:0] data;
        logic [7:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic [3:0]      warm;
    logic [7:0]      tag;
    logic            ovf;

    logic            warm_done, evt, pop, push, drop, nonempty, at_full;
    entry_t          head;

    // Decode this cycle's sample event, handshake and accept/drop decision.
    always_comb begin
        warm_done = (warm >= 4'(SKIP));
        nonempty  = (cnt != '0);
        at_full   = (cnt == CW'(DEPTH));
        evt       = en && warm_done;
        pop       = nonempty && out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = evt && (!at_full || pop);
        drop      = evt && !push;
    end

    // Warm-up counter: advances on enabled cycles and saturates at SKIP.
    always_ff @(posedge clk) begin
        if (reset)
            warm <= '0;
        else if (en && !warm_done)
            warm <= warm + 4'd1;
    end

    // Sequence tag advances on every post-warm-up event, kept or dropped,
    // so the consumer can spot gaps; sticky overflow records any drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
            ovf <= 1'b0;
        end else begin
            if (evt)  tag <= tag + 8'd1;
            if (drop) ovf <= 1'b1;
        end
    end

    // Pointer and occupancy update; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset: emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= '{data: y_in, tag: tag};
    end

    // Show-ahead head, forced to zero when the FIFO is empty.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = nonempty;
        out_data  = nonempty ? head.data : '0;
        out_tag   = nonempty ? head.tag  : '0;
        count     = cnt;
        full      = at_full;
        empty     = !nonempty;
        overflow  = ovf;
    end
endmodule

// File: tb/tb_cs_y_collector.sv
// Directed bench for cs_y_collector (DEPTH=16, SKIP=1).
module tb_cs_y_collector;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] y_in;
    logic       en;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic [7:0] out_tag;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int errs = 0;
    int nchk = 0;

    cs_y_collector #(.DEPTH(16), .SKIP(1)) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .en(en), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; out_ready = 1'b0; y_in = '0;
        tick();
        reset = 1'b0;
    endtask

    // One discarded warm-up event.
    task automatic warm();
        en = 1'b1; out_ready = 1'b0; y_in = 10'd999;
        tick();
        chk("warm_discard_cnt", count, 0);
        en = 1'b0;
    endtask

    initial begin
        int ykept;
        do_reset();
        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_ovf", overflow, 0);

        // Warm-up: 100 discarded, 101 first kept with tag 0
        en = 1'b1; out_ready = 1'b0;
        y_in = 10'd100; tick();
        chk("wu_after100_cnt", count, 0);
        y_in = 10'd101; tick();
        chk("wu_valid", out_valid, 1);
        chk("wu_data", out_data, 101);
        chk("wu_tag", out_tag, 0);
        y_in = 10'd102; tick();
        chk("wu_cnt3", count, 2);

        // Stall hold
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", out_data, 101);
            chk("hold_tag", out_tag, 0);
            chk("hold_cnt", count, 2);
            chk("hold_valid", out_valid, 1);
        end

        // Continuous drain, 300 kept samples, tag wraps
        do_reset();
        warm();
        en = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ykept = k % 41;
            y_in = 10'(ykept);
            tick();
            chk("drain_cnt", count, 1);
            chk("drain_valid", out_valid, 1);
            chk("drain_tag", out_tag, k & 255);
            chk("drain_data", out_data, ykept);
        end
        en = 1'b0; tick();
        chk("drain_end_empty", empty, 1);

        // Fill and overflow
        do_reset();
        warm();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            y_in = 10'(200 + i);
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_cnt", count, 16);
        chk("fill_ovf", overflow, 1);
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_dr_tag", out_tag, i);
            chk("fill_dr_data", out_data, 200 + i);
            tick();
        end
        out_ready = 1'b0;
        chk("fill_empty", empty, 1);
        chk("fill_ovf_sticky", overflow, 1);

        // Simultaneous push/pop at full
        do_reset();
        warm();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            y_in = 10'(300 + i);
            tick();
        end
        chk("pp_full_before", full, 1);
        out_ready = 1'b1; y_in = 10'h3FF;
        tick();
        chk("pp_cnt", count, 16);
        chk("pp_ovf", overflow, 0);
        en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("pp_dr_tag", out_tag, i);
            chk("pp_dr_data", out_data, 300 + i);
            tick();
        end
        chk("pp_last_tag", out_tag, 16);
        chk("pp_last_data", out_data, 10'h3FF);
        tick();
        chk("pp_empty", empty, 1);
        out_ready = 1'b0;

        // Mid-operation reset
        do_reset();
        warm();
        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            y_in = 10'(i);
            tick();
        end
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        chk("mid_cnt7", count, 7);
        chk("mid_ovf", overflow, 1);
        reset = 1'b1; en = 1'b1; out_ready = 1'b1; y_in = 10'd77;
        tick();
        reset = 1'b0; en = 1'b0; out_ready = 1'b0;
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        en = 1'b1;
        y_in = 10'd50; tick();
        chk("mid_skip_cnt", count, 0);
        y_in = 10'd51; tick();
        en = 1'b0;
        chk("mid_kept_tag", out_tag, 0);
        chk("mid_kept_data", out_data, 51);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
